systolic_pe_mac: RTL and testbench

SYSTOLIC_PE_MAC -- requirements
Module: systolic_pe_mac

---
 rtl/systolic_pe_mac.sv | 152 +++++++++++++++
 tb/tb_systolic_pe_mac.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_mac.sv
// Systolic-array processing element: forwards operands to its neighbours and
// accumulates pipelined products into saturating per-tile results.
module systolic_pe_mac #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
   parameter int MUL_LAT    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   input  logic                  last_in,
   input  logic                  signed_mode,
   output logic [DATA_WIDTH-1:0] a_out,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic                  valid_out,
   output logic                  last_out,
   output logic                  signed_out,
   output logic [ACC_WIDTH-1:0]  res_data,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  res_sat,
   output logic                  ovf_err
);

   localparam int PW  = 2*DATA_WIDTH;
   localparam int EXT = ACC_WIDTH + 1 - PW;

   logic [DATA_WIDTH-1:0] a_q, b_q;
   logic                  valid_q, last_q, signed_q;

   logic [PW-1:0]         pipe_prod_q [MUL_LAT];
   logic [MUL_LAT-1:0]    pipe_vld_q, pipe_last_q, pipe_sgn_q;

   logic [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                  tile_sat_q, tile_sat_d;
   logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
   logic                  res_valid_q, res_valid_d;
   logic                  res_sat_q, res_sat_d;
   logic                  ovf_q, ovf_d;

   // Extending both operands to PW bits by the beat's mode lets one unsigned
   // multiplier produce either product exactly in its low PW bits.
   logic [PW-1:0] a_ext, b_ext, prod_in;
   assign a_ext   = {{DATA_WIDTH{signed_mode & a_in[DATA_WIDTH-1]}}, a_in};
   assign b_ext   = {{DATA_WIDTH{signed_mode & b_in[DATA_WIDTH-1]}}, b_in};
   assign prod_in = a_ext * b_ext;

   logic [PW-1:0]      arr_prod;
   logic               arr_vld, arr_last, arr_sgn;
   logic [ACC_WIDTH:0] acc_ext, prod_ext, sum;
   logic               clamp, new_res;
   logic [ACC_WIDTH-1:0] sat_val;

   assign arr_prod = pipe_prod_q[MUL_LAT-1];
   assign arr_vld  = pipe_vld_q[MUL_LAT-1];
   assign arr_last = pipe_last_q[MUL_LAT-1];
   assign arr_sgn  = pipe_sgn_q[MUL_LAT-1];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      acc_ext  = {arr_sgn & acc_q[ACC_WIDTH-1], acc_q};
      prod_ext = {{EXT{arr_sgn & arr_prod[PW-1]}}, arr_prod};
      sum      = acc_ext + prod_ext;
      clamp    = arr_sgn ? (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];
      sat_val  = sum[ACC_WIDTH-1:0];
      if (clamp) begin
         if (arr_sgn) sat_val = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
         else         sat_val = {ACC_WIDTH{1'b1}};
      end

      new_res     = arr_vld & arr_last;
      acc_d       = acc_q;
      tile_sat_d  = tile_sat_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      res_sat_d   = res_sat_q;
      ovf_d       = ovf_q;

      if (new_res) begin
         res_data_d  = sat_val;
         res_sat_d   = tile_sat_q | clamp;
         res_valid_d = 1'b1;
         ovf_d       = ovf_q | (res_valid_q & ~res_ready);
         acc_d       = '0;
         tile_sat_d  = 1'b0;
      end else begin
         if (arr_vld) begin
            acc_d      = sat_val;
            tile_sat_d = tile_sat_q | clamp;
         end
         if (res_ready) res_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; blocking is reserved for always_comb.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q         <= '0;
         b_q         <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         signed_q    <= 1'b0;
         // NOTE: product stages are cleared along with their valid bits so reset leaves no stale data anywhere.
         for (int i = 0; i < MUL_LAT; i++) pipe_prod_q[i] <= '0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
         pipe_sgn_q  <= '0;
         acc_q       <= '0;
         tile_sat_q  <= 1'b0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         res_sat_q   <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         a_q      <= a_in;
         b_q      <= b_in;
         valid_q  <= in_valid;
         last_q   <= last_in;
         signed_q <= signed_mode;
         for (int i = MUL_LAT-1; i > 0; i--) begin
            pipe_prod_q[i] <= pipe_prod_q[i-1];
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_last_q[i] <= pipe_last_q[i-1];
            pipe_sgn_q[i]  <= pipe_sgn_q[i-1];
         end
         pipe_prod_q[0] <= prod_in;
         pipe_vld_q[0]  <= in_valid;
         pipe_last_q[0] <= in_valid & last_in;
         pipe_sgn_q[0]  <= in_valid & signed_mode;
         acc_q       <= acc_d;
         tile_sat_q  <= tile_sat_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         res_sat_q   <= res_sat_d;
         ovf_q       <= ovf_d;
      end
   end

   assign a_out      = a_q;
   assign b_out      = b_q;
   assign valid_out  = valid_q;
   assign last_out   = last_q;
   assign signed_out = signed_q;
   assign res_data   = res_data_q;
   assign res_valid  = res_valid_q;
   assign res_sat    = res_sat_q;
   assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Bench for systolic_pe_mac: directed tile scenarios plus random traffic,
// every cycle compared against an arithmetic model of tiles and results.
module tb_systolic_pe_mac;

   localparam int DW  = 8;
   localparam int AW  = 16;
   localparam int LAT = 2;

   localparam longint AMAX = (longint'(1) << AW) - 1;
   localparam longint SMAX = (longint'(1) << (AW-1)) - 1;
   localparam longint SMIN = -(longint'(1) << (AW-1));

   logic          clk = 1'b0;
   logic          rst, in_valid, last_in, signed_mode, res_ready;
   logic [DW-1:0] a_in, b_in, a_out, b_out;
   logic          valid_out, last_out, signed_out, res_valid, res_sat, ovf_err;
   logic [AW-1:0] res_data;

   systolic_pe_mac #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MUL_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
      .last_in(last_in), .signed_mode(signed_mode),
      .a_out(a_out), .b_out(b_out), .valid_out(valid_out), .last_out(last_out),
      .signed_out(signed_out), .res_data(res_data), .res_valid(res_valid),
      .res_ready(res_ready), .res_sat(res_sat), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: beats wait LAT edges in a queue, then tiles are summed with
   // plain integer arithmetic and clamped to the arriving beat's range.
   typedef struct {bit v; bit l; bit s; int a; int b;} beat_t;
   beat_t  q[$];
   longint m_acc, m_res_data;
   bit     m_tile_sat, m_res_valid, m_res_sat, m_ovf;
   int     m_a_out, m_b_out;
   bit     m_valid_out, m_last_out, m_signed_out;

   task automatic acc_add(input longint acc, input beat_t bt, output longint res, output bit clamp);
      longint pa, pb, t;
      pa = bt.a; pb = bt.b;
      clamp = 1'b0;
      if (bt.s) begin
         if (pa > 127) pa -= 256;
         if (pb > 127) pb -= 256;
         t = (acc > SMAX) ? acc - (AMAX + 1) : acc;
         t = t + pa * pb;
         if (t > SMAX) begin t = SMAX; clamp = 1'b1; end
         if (t < SMIN) begin t = SMIN; clamp = 1'b1; end
         res = t & AMAX;
      end else begin
         t = acc + pa * pb;
         if (t > AMAX) begin t = AMAX; clamp = 1'b1; end
         res = t;
      end
   endtask

   task automatic model_edge(input bit v, input int a, input int b, input bit l,
                             input bit s, input bit r, input bit rs);
      beat_t  nb, ab;
      bit     new_res, clamp;
      longint sum;
      if (rs) begin
         q.delete();
         m_acc = 0; m_tile_sat = 0; m_res_data = 0; m_res_valid = 0;
         m_res_sat = 0; m_ovf = 0; m_a_out = 0; m_b_out = 0;
         m_valid_out = 0; m_last_out = 0; m_signed_out = 0;
         return;
      end
      nb = '{v, l, s, a, b};
      q.push_back(nb);
      new_res = 1'b0;
      if (q.size() > LAT) begin
         ab = q.pop_front();
         if (ab.v) begin
            acc_add(m_acc, ab, sum, clamp);
            if (ab.l) begin
               new_res = 1'b1;
               if (m_res_valid && !r) m_ovf = 1'b1;
               m_res_data  = sum;
               m_res_sat   = m_tile_sat | clamp;
               m_res_valid = 1'b1;
               m_acc = 0; m_tile_sat = 1'b0;
            end else begin
               m_acc = sum;
               m_tile_sat = m_tile_sat | clamp;
            end
         end
      end
      if (!new_res && r) m_res_valid = 1'b0;
      m_a_out = a; m_b_out = b;
      m_valid_out = v; m_last_out = l; m_signed_out = s;
   endtask

   task automatic compare_all();
      check("a_out",      a_out,      m_a_out);
      check("b_out",      b_out,      m_b_out);
      check("valid_out",  valid_out,  m_valid_out);
      check("last_out",   last_out,   m_last_out);
      check("signed_out", signed_out, m_signed_out);
      check("res_data",   res_data,   m_res_data);
      check("res_valid",  res_valid,  m_res_valid);
      check("res_sat",    res_sat,    m_res_sat);
      check("ovf_err",    ovf_err,    m_ovf);
   endtask

   task automatic step(input bit v, input int a, input int b, input bit l,
                       input bit s, input bit r, input bit rs);
      rst = rs; in_valid = v; a_in = DW'(a); b_in = DW'(b);
      last_in = l; signed_mode = s; res_ready = r;
      @(posedge clk);
      model_edge(v, a, b, l, s, r, rs);
      #1 compare_all();
   endtask

   task automatic idle(input bit r);
      step(1'b0, 0, 0, 1'b0, 1'b0, r, 1'b0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0;
      last_in = 1'b0; signed_mode = 1'b0; res_ready = 1'b0;
      #1;
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data",  res_data,  0);

      // Unsigned dot product: 3*4 + 5*6 + 7*8 = 98
      step(1, 3, 4, 0, 0, 0, 0);
      check("dot_a_out", a_out, 3);
      step(1, 5, 6, 0, 0, 0, 0);
      step(1, 7, 8, 1, 0, 0, 0);
      idle(0);
      check("dot_not_early", res_valid, 0);
      idle(0);
      check("dot_valid", res_valid, 1);
      check("dot_data",  res_data,  98);
      check("dot_sat",   res_sat,   0);
      idle(1);
      check("drain_valid", res_valid, 0);
      check("drain_hold",  res_data,  98);

      // Signed: (-1*2) + (-128*-128) = 16382
      step(1, 8'hFF, 8'h02, 0, 1, 0, 0);
      step(1, 8'h80, 8'h80, 1, 1, 0, 0);
      idle(0); idle(0);
      check("signed_data", res_data, 16382);
      idle(1);

      // Unsigned saturation
      step(1, 255, 255, 0, 0, 0, 0);
      step(1, 255, 255, 1, 0, 0, 0);
      idle(0); idle(0);
      check("usat_data", res_data, 16'hFFFF);
      check("usat_flag", res_sat,  1);
      idle(1);

      // Signed saturation: 3 * (-128*127) = -48768 clamps to -32768
      step(1, 8'h80, 8'h7F, 0, 1, 0, 0);
      step(1, 8'h80, 8'h7F, 0, 1, 0, 0);
      step(1, 8'h80, 8'h7F, 1, 1, 0, 0);
      idle(0); idle(0);
      check("ssat_data", res_data, 16'h8000);
      check("ssat_flag", res_sat,  1);
      idle(1);

      // Overwrite of an undrained result
      step(1, 2, 3, 1, 0, 0, 0);
      step(1, 4, 5, 1, 0, 0, 0);
      idle(0); idle(0);
      check("ovf_data", res_data, 20);
      check("ovf_flag", ovf_err,  1);
      idle(1);
      check("ovf_sticky", ovf_err, 1);

      // Reset mid-tile discards in-flight beats
      step(1, 9, 9, 0, 0, 0, 0);
      step(1, 9, 9, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      check("rstmid_a_out",     a_out,     0);
      check("rstmid_valid_out", valid_out, 0);
      check("rstmid_ovf",       ovf_err,   0);
      check("rstmid_res_data",  res_data,  0);
      step(1, 1, 1, 1, 0, 0, 0);
      idle(0);
      check("rstmid_no_stale", res_valid, 0);
      idle(0);
      check("rstmid_data", res_data, 1);
      idle(1);

      // Back-to-back results while draining: no overflow
      step(1, 2, 3, 1, 0, 1, 0);
      step(1, 4, 5, 1, 0, 1, 0);
      idle(1); idle(1);
      check("noovf_data",  res_data,  20);
      check("noovf_valid", res_valid, 1);
      check("noovf_flag",  ovf_err,   0);
      idle(1);

      // Bubbles inside a tile; last_in on invalid beats is ignored
      step(1, 2, 2, 0, 0, 0, 0);
      idle(0); idle(0);
      step(1, 3, 3, 1, 0, 0, 0);
      idle(0); idle(0);
      check("bubble_data", res_data, 13);
      idle(1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0);
      check("bubble_last_out", last_out,  1);
      check("bubble_no_res",   res_valid, 0);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         int a, b;
         a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h80 : 8'hFF)
                                         : int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         step($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 63) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
